// File: rtl/icosoc_uart_ctrl_bridge.sv
// UART debug initiator for the icosoc ctrl bus.
// Serial command frames become one ctrl_wr/ctrl_rd transaction; replies go back on txd.
module icosoc_uart_ctrl_bridge #(
    parameter int BAUD_RATE     = 9600,
    parameter int CLOCK_FREQ_HZ = 6000000,
    parameter int BUS_TIMEOUT   = 255,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rxd,
    output logic        txd,
    output logic        ctrl_wr,
    output logic        ctrl_rd,
    output logic [7:0]  ctrl_addr,
    output logic [31:0] ctrl_wdat,
    input  logic [31:0] ctrl_rdat,
    input  logic        ctrl_done,
    output logic        busy,
    output logic        rx_err
);
    localparam int HALF = CLOCK_FREQ_HZ / (2 * BAUD_RATE);
    localparam int CW = $clog2(3 * HALF + 1);
    localparam logic [CW-1:0] FIRST = CW'(3 * HALF - 1);
    localparam logic [CW-1:0] BITC = CW'(2 * HALF - 1);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [BW-1:0] BLAST = BW'(BUS_TIMEOUT - 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [FW-1:0] FLAST = FW'(FRAME_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    logic          rx_s1, rx_s2, rx_s3, rx_fall;
    logic          rx_busy, rx_valid, rx_ferr;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic          tx_busy, tx_ready, tx_load;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [7:0]    tx_sh;

    state_t        state, state_n;
    logic          is_wr, is_wr_n;
    logic [1:0]    dcnt, dcnt_n;
    logic [7:0]    addr_n;
    logic [31:0]   wdat_n;
    logic          wr_n, rd_n, rx_err_n;
    logic [BW-1:0] bus_cnt, bus_cnt_n;
    logic [FW-1:0] frame_cnt, frame_cnt_n;
    logic [31:0]   resp_q, resp_q_n;
    logic [2:0]    resp_left, resp_left_n;

    assign rx_fall = rx_s3 & ~rx_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {rx_s3, rx_s2, rx_s1} <= 3'b111;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rxd};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_busy) begin
                if (rx_fall) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= FIRST;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else if (rx_bit == 4'd8) begin
                rx_busy  <= 1'b0;
                rx_valid <= rx_s2;
                rx_ferr  <= ~rx_s2;
            end else begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 4'd1;
                rx_cnt <= BITC;
            end
        end
    end

    // Ready during the last stop-bit cycle so reply bytes leave back-to-back.
    assign tx_ready = !tx_busy || (tx_cnt == '0 && tx_bit == 4'd9);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
        end else if (tx_load) begin
            txd     <= 1'b0;
            tx_busy <= 1'b1;
            tx_cnt  <= BITC;
            tx_bit  <= '0;
            tx_sh   <= resp_q[7:0];
        end else if (tx_busy) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                txd    <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[7:1]};
                tx_bit <= tx_bit + 4'd1;
                tx_cnt <= BITC;
            end
        end
    end

    always_comb begin
        state_n     = state;
        is_wr_n     = is_wr;
        dcnt_n      = dcnt;
        addr_n      = ctrl_addr;
        wdat_n      = ctrl_wdat;
        wr_n        = ctrl_wr;
        rd_n        = ctrl_rd;
        bus_cnt_n   = bus_cnt;
        frame_cnt_n = frame_cnt;
        resp_q_n    = resp_q;
        resp_left_n = resp_left;
        rx_err_n    = 1'b0;
        tx_load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_ferr) begin
                    rx_err_n = 1'b1;
                end else if (rx_valid) begin
                    if (rx_sh == 8'h57 || rx_sh == 8'h52) begin
                        is_wr_n     = (rx_sh == 8'h57);
                        frame_cnt_n = '0;
                        state_n     = ADDR;
                    end else begin
                        resp_q_n    = 32'h3F;
                        resp_left_n = 3'd1;
                        state_n     = RESP;
                    end
                end
            end
            ADDR, DATA: begin
                if (rx_ferr) begin
                    rx_err_n = 1'b1;
                    state_n  = IDLE;
                end else if (rx_valid) begin
                    frame_cnt_n = '0;
                    bus_cnt_n   = '0;
                    if (state == ADDR) begin
                        addr_n  = rx_sh;
                        dcnt_n  = '0;
                        state_n = is_wr ? DATA : BUS;
                        rd_n    = !is_wr;
                    end else begin
                        wdat_n = {rx_sh, ctrl_wdat[31:8]};
                        dcnt_n = dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            wr_n    = 1'b1;
                            state_n = BUS;
                        end
                    end
                end else if (!(rx_busy || rx_fall)) begin
                    if (frame_cnt == FLAST) begin
                        rx_err_n = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                    end
                end
            end
            BUS: begin
                if (ctrl_done) begin
                    wr_n        = 1'b0;
                    rd_n        = 1'b0;
                    resp_q_n    = ctrl_rd ? ctrl_rdat : 32'h4B;
                    resp_left_n = ctrl_rd ? 3'd4 : 3'd1;
                    state_n     = RESP;
                end else if (bus_cnt == BLAST) begin
                    wr_n        = 1'b0;
                    rd_n        = 1'b0;
                    resp_q_n    = 32'h54;
                    resp_left_n = 3'd1;
                    state_n     = RESP;
                end else begin
                    bus_cnt_n = bus_cnt + 1'b1;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    if (resp_left != 3'd0) begin
                        tx_load     = 1'b1;
                        resp_q_n    = {8'h00, resp_q[31:8]};
                        resp_left_n = resp_left - 3'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            dcnt      <= '0;
            ctrl_addr <= '0;
            ctrl_wdat <= '0;
            ctrl_wr   <= 1'b0;
            ctrl_rd   <= 1'b0;
            bus_cnt   <= '0;
            frame_cnt <= '0;
            resp_q    <= '0;
            resp_left <= '0;
            rx_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            is_wr     <= is_wr_n;
            dcnt      <= dcnt_n;
            ctrl_addr <= addr_n;
            ctrl_wdat <= wdat_n;
            ctrl_wr   <= wr_n;
            ctrl_rd   <= rd_n;
            bus_cnt   <= bus_cnt_n;
            frame_cnt <= frame_cnt_n;
            resp_q    <= resp_q_n;
            resp_left <= resp_left_n;
            rx_err    <= rx_err_n;
            busy      <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_icosoc_uart_ctrl_bridge.sv
// Scoreboard bench for icosoc_uart_ctrl_bridge.
// Frames go in on rxd; bus and txd monitors check against queued expectations.
module tb_icosoc_uart_ctrl_bridge;
    localparam int BIT = 8;
    localparam int BTO = 16;
    localparam int FTO = 200;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rxd = 1'b1;
    logic        txd, ctrl_wr, ctrl_rd, busy, rx_err;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat = '0;
    logic        ctrl_done = 1'b0;

    always #5 clk = ~clk;

    icosoc_uart_ctrl_bridge #(
        .BAUD_RATE(10000),
        .CLOCK_FREQ_HZ(80000),
        .BUS_TIMEOUT(BTO),
        .FRAME_TIMEOUT(FTO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rxd(rxd),
        .txd(txd),
        .ctrl_wr(ctrl_wr),
        .ctrl_rd(ctrl_rd),
        .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat),
        .ctrl_rdat(ctrl_rdat),
        .ctrl_done(ctrl_done),
        .busy(busy),
        .rx_err(rx_err)
    );

    typedef struct {
        bit        wr;
        bit [7:0]  addr;
        bit [31:0] wdat;
        int        len;
    } bus_t;
    typedef struct {
        bit [7:0] b;
        bit       contig;
    } tx_t;

    bus_t exp_bus[$];
    tx_t  exp_tx[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   bus_seen = 0;
    int   err_seen = 0;
    int   inject_req = 0;
    bit   silent = 0;
    bit   ignore = 0;
    bit   mon_busy = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (rx_err) err_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    initial begin : responder
        int age = 0;
        int done_inj = 0;
        forever begin
            @(negedge clk);
            ctrl_done = 1'b0;
            if (inject_req != done_inj) begin
                done_inj  = inject_req;
                ctrl_done = 1'b1;
            end else if ((ctrl_wr || ctrl_rd) && resetn) begin
                age++;
                if (age == 3 && !silent) ctrl_done = 1'b1;
            end else begin
                age = 0;
            end
        end
    end

    initial begin : bus_mon
        bit          prev = 0;
        bit          have = 0;
        bit          unstable = 0;
        int          hi = 0;
        bus_t        cur;
        logic [7:0]  a0;
        logic [31:0] d0;
        forever begin
            @(negedge clk);
            if (ctrl_wr && ctrl_rd) fail("both_strobes", {ctrl_wr, ctrl_rd});
            if ((ctrl_wr || ctrl_rd) && !prev) begin
                bus_seen++;
                hi = 1;
                unstable = 0;
                a0 = ctrl_addr;
                d0 = ctrl_wdat;
                have = 0;
                if (exp_bus.size() == 0) begin
                    if (!ignore) fail("bus_unexpected", {24'h0, ctrl_addr});
                end else begin
                    have = 1;
                    cur = exp_bus.pop_front();
                    chk("bus_kind", {31'h0, ctrl_wr}, {31'h0, cur.wr});
                    chk("bus_addr", {24'h0, ctrl_addr}, {24'h0, cur.addr});
                    if (cur.wr) chk("bus_wdat", ctrl_wdat, cur.wdat);
                end
            end else if (ctrl_wr || ctrl_rd) begin
                hi++;
                if (ctrl_addr !== a0 || ctrl_wdat !== d0) unstable = 1;
            end else if (prev) begin
                if (have && !ignore) begin
                    chk("bus_len", hi, cur.len);
                    chk("bus_stable", {31'h0, unstable}, 32'h0);
                end
                have = 0;
            end
            prev = ctrl_wr || ctrl_rd;
        end
    end

    initial begin : tx_mon
        logic       prev = 1'b1;
        logic [7:0] b;
        logic       s0, s9;
        int         st;
        int         last_st = -1000;
        tx_t        e;
        forever begin
            @(negedge clk);
            if (prev && !txd && resetn) begin
                mon_busy = 1;
                st = cyc;
                repeat (BIT / 2) @(negedge clk);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                s9 = txd;
                if (!ignore) begin
                    if (exp_tx.size() == 0) begin
                        fail("tx_unexpected", {24'h0, b});
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx_byte", {22'h0, s9, b, s0}, {22'h0, 1'b1, e.b, 1'b0});
                        if (e.contig) chk("tx_gap", st - last_st, 10 * BIT);
                    end
                end
                last_st = st;
                mon_busy = 0;
            end
            prev = txd;
        end
    end

    task automatic send_byte(input logic [7:0] v, input logic stop);
        logic [9:0] f;
        f = {stop, v, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        send_byte(a, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic do_read(input logic [7:0] a);
        send_byte(8'h52, 1'b1);
        send_byte(a, 1'b1);
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input int len);
        exp_bus.push_back('{1'b1, a, d, len});
        exp_tx.push_back('{(len == BTO) ? 8'h54 : 8'h4B, 1'b0});
    endtask

    task automatic model_read(input logic [7:0] a, input logic [31:0] r);
        exp_bus.push_back('{1'b0, a, 32'h0, 3});
        for (int i = 0; i < 4; i++) exp_tx.push_back('{r[8*i +: 8], i != 0});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy || mon_busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(name, {31'h0, n >= 4000}, 32'h0);
    endtask

    task automatic reset_now();
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("rst_txd", {31'h0, txd}, 32'h1);
        chk("rst_wr", {31'h0, ctrl_wr}, 32'h0);
        chk("rst_rd", {31'h0, ctrl_rd}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        exp_tx.delete();
        exp_bus.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  a, op;
        logic [31:0] d;
        int          e0, b0, bad;

        #12;
        chk("reset_txd", {31'h0, txd}, 32'h1);
        chk("reset_strobes", {30'h0, ctrl_wr, ctrl_rd}, 32'h0);
        chk("reset_addr", {24'h0, ctrl_addr}, 32'h0);
        chk("reset_wdat", ctrl_wdat, 32'h0);
        chk("reset_busy_err", {30'h0, busy, rx_err}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);

        model_write(8'h08, 32'h12345678, 3);
        do_write(8'h08, 32'h12345678);
        chk("busy_in_write", {31'h0, busy}, 32'h1);
        wait_done("write_done");
        chk("busy_after_write", {31'h0, busy}, 32'h0);

        ctrl_rdat = 32'hDEADBEEF;
        model_read(8'h04, 32'hDEADBEEF);
        do_read(8'h04);
        chk("busy_in_read", {31'h0, busy}, 32'h1);
        wait_done("read_done");

        b0 = bus_seen;
        exp_tx.push_back('{8'h3F, 1'b0});
        send_byte(8'h41, 1'b1);
        wait_done("badop_done");
        chk("badop_no_strobe", bus_seen, b0);
        ctrl_rdat = 32'hA5C30F96;
        model_read(8'h33, 32'hA5C30F96);
        do_read(8'h33);
        wait_done("read_after_badop");

        silent = 1;
        model_write(8'h10, 32'hCAFEF00D, BTO);
        do_write(8'h10, 32'hCAFEF00D);
        wait_done("timeout_done");
        silent = 0;
        b0 = bus_seen;
        inject_req++;
        repeat (100) @(negedge clk);
        chk("late_done_no_strobe", bus_seen, b0);
        chk("late_done_idle", {30'h0, busy, txd}, 32'h1);

        e0 = err_seen;
        b0 = bus_seen;
        send_byte(8'h57, 1'b1);
        send_byte(8'h08, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_pulse", err_seen, e0 + 1);
        chk("ferr_busy", {31'h0, busy}, 32'h0);
        send_byte(8'h57, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h78, 1'b1);
        repeat (FTO + 50) @(negedge clk);
        chk("frame_to_pulse", err_seen, e0 + 2);
        chk("frame_to_busy", {31'h0, busy}, 32'h0);
        chk("err_no_strobe", bus_seen, b0);
        model_write(8'h21, 32'h0BADBEEF, 3);
        do_write(8'h21, 32'h0BADBEEF);
        wait_done("write_after_errs");

        silent = 1;
        model_write(8'h44, 32'h11223344, BTO);
        do_write(8'h44, 32'h11223344);
        begin
            int n = 0;
            while (!ctrl_wr && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midbus_strobe", {31'h0, ctrl_wr}, 32'h1);
        repeat (2) @(negedge clk);
        ignore = 1;
        reset_now();
        silent = 0;
        repeat (150) @(negedge clk);
        ignore = 0;

        ctrl_rdat = 32'h01020304;
        model_read(8'h55, 32'h01020304);
        do_read(8'h55);
        begin
            int n = 0;
            while (txd && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midresp_started", {31'h0, txd}, 32'h0);
        repeat (20) @(negedge clk);
        ignore = 1;
        reset_now();
        repeat (150) @(negedge clk);
        ignore = 0;
        b0 = bus_seen;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!txd || busy || ctrl_wr || ctrl_rd) bad++;
        end
        chk("idle_after_reset", bad, 0);
        chk("idle_no_strobe", bus_seen, b0);

        for (int k = 0; k < 10; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 255));
            d = $urandom();
            if (sel < 5) begin
                model_write(a, d, 3);
                do_write(a, d);
            end else if (sel < 9) begin
                ctrl_rdat = d;
                model_read(a, d);
                do_read(a);
            end else begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h57 || op == 8'h52) op = 8'h41;
                exp_tx.push_back('{8'h3F, 1'b0});
                send_byte(op, 1'b1);
            end
            wait_done("rand_done");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
